adc_readout_arb: RTL and testbench

ADC_READOUT_ARB -- requirements
Module: adc_readout_arb

---
 rtl/adc_readout_arb_pkg.sv | 30 +++
 rtl/adc_readout_arb_chan_pick.sv | 24 ++
 rtl/adc_readout_arb.sv | 182 ++++++++++++++++++
 tb/tb_adc_readout_arb.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_readout_arb_pkg.sv
// Shared oscilloscope package: readout FSM state encoding,
// default header/trailer bytes and payload counter helpers.
package adc_readout_arb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_END,
        S_HDR,
        S_RD,
        S_CAP,
        S_SEND,
        S_NEXT,
        S_TRL
    } state_t;

    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
    localparam logic [7:0] TRAILER_DEF  = 8'h55;

    localparam int               CNT_W   = 13;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment for the per-channel payload byte counter.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_readout_arb_chan_pick.sv
// Lowest-set-bit picker: returns index of the lowest set bit of i_vec.
// Ports: i_vec (candidate vector), o_idx (index), o_found (any bit set).
module chan_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                o_idx   = W'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_readout_arb.sv
// ADC capture/readout arbiter: arms all channels, waits for capture
// complete, then streams header + payload bytes per enabled channel
// and a trailer byte.
// Ports: Clk, Reset_n (async low); start/ch_mask host request;
// ch_end/ch_empty/ch_data/ch_rdreq per-channel FIFO side;
// adc_bg capture restart; out_data/out_valid/out_ready/out_last
// byte stream; busy = not idle.
module adc_readout_arb
    import adc_readout_arb_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
    parameter logic [7:0] TRAILER  = TRAILER_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [NUM_CH-1:0]     ch_end,
    input  logic [NUM_CH-1:0]     ch_empty,
    input  logic [8*NUM_CH-1:0]   ch_data,
    output logic [NUM_CH-1:0]     ch_rdreq,
    output logic                  adc_bg,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t             r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [CH_W-1:0]    r_ch;
    logic               r_first;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_out_last;

    state_t             w_nstate;
    logic [NUM_CH-1:0]  w_nmask;
    logic [CH_W-1:0]    w_nch;
    logic               w_nfirst;
    logic [CNT_W-1:0]   w_ncnt;
    logic [7:0]         w_ndata;
    logic               w_nvalid;
    logic               w_nlast;

    logic               w_hs;
    logic [NUM_CH-1:0]  w_low;
    logic [NUM_CH-1:0]  w_above;
    logic [NUM_CH-1:0]  w_pick_vec;
    logic [CH_W-1:0]    w_pick_idx;
    logic               w_pick_found;
    logic [NUM_CH-1:0]  w_rdreq;

    assign w_hs = r_out_valid & out_ready;

    // Channels strictly above the current one.
    assign w_low   = NUM_CH'(1) << r_ch;
    assign w_above = ~((w_low << 1) - NUM_CH'(1));

    // First pick uses the whole mask; later picks only higher channels.
    assign w_pick_vec = (r_state == S_WAIT_END) ? r_mask
                                                : (r_mask & w_above);

    chan_pick #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_pick (
        .i_vec   (w_pick_vec),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_nstate = r_state;
        w_nmask  = r_mask;
        w_nch    = r_ch;
        w_nfirst = r_first;
        w_ncnt   = r_cnt;
        w_ndata  = r_out_data;
        unique case (r_state)
            S_IDLE: begin
                if (start && (|ch_mask)) begin
                    w_nmask  = ch_mask;
                    w_nstate = S_ARM;
                end
            end
            S_ARM: begin
                w_nfirst = 1'b1;
                w_nstate = S_WAIT_END;
            end
            S_WAIT_END: begin
                // ch_end may still show the previous capture for one cycle.
                w_nfirst = 1'b0;
                if (!r_first && ((ch_end & r_mask) == r_mask)) begin
                    w_nch    = w_pick_idx;
                    w_ndata  = HDR_BASE + 8'(w_pick_idx);
                    w_ncnt   = '0;
                    w_nstate = S_HDR;
                end
            end
            S_HDR: begin
                if (w_hs) w_nstate = S_RD;
            end
            S_RD: begin
                w_nstate = ch_empty[r_ch] ? S_NEXT : S_CAP;
            end
            S_CAP: begin
                // Normal-mode FIFO: q is valid the cycle after rdreq.
                w_ndata  = ch_data[{r_ch, 3'b000} +: 8];
                w_nstate = S_SEND;
            end
            S_SEND: begin
                if (w_hs) begin
                    w_ncnt   = sat_inc(r_cnt);
                    w_nstate = S_RD;
                end
            end
            S_NEXT: begin
                if (w_pick_found) begin
                    w_nch    = w_pick_idx;
                    w_ndata  = HDR_BASE + 8'(w_pick_idx);
                    w_ncnt   = '0;
                    w_nstate = S_HDR;
                end else begin
                    w_ndata  = TRAILER;
                    w_nstate = S_TRL;
                end
            end
            S_TRL: begin
                if (w_hs) begin
                    w_nmask  = '0;
                    w_nch    = '0;
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        w_nvalid = (w_nstate == S_HDR) || (w_nstate == S_SEND)
                || (w_nstate == S_TRL);
        w_nlast  = (w_nstate == S_TRL);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_ch        <= '0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_mask      <= w_nmask;
            r_ch        <= w_nch;
            r_first     <= w_nfirst;
            r_cnt       <= w_ncnt;
            r_out_data  <= w_ndata;
            r_out_valid <= w_nvalid;
            r_out_last  <= w_nlast;
        end
    end

    always_comb begin
        w_rdreq = '0;
        if ((r_state == S_RD) && !ch_empty[r_ch]) w_rdreq[r_ch] = 1'b1;
    end

    assign ch_rdreq  = w_rdreq;
    assign adc_bg    = (r_state == S_ARM);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_adc_readout_arb.sv
// Testbench for adc_readout_arb: FIFO models, ready pattern generator,
// scoreboard of expected {last,byte} entries.
module tb_adc_readout_arb;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ch_mask = 4'h0;
    logic [3:0]  ch_end = 4'h0;
    logic [3:0]  ch_empty;
    logic [31:0] ch_data;
    logic [3:0]  ch_rdreq;
    logic        adc_bg;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_bytes = 0;
    int n_frames = 0;
    int n_bg = 0;
    int n_rd1 = 0;
    int ready_mode = 0;
    int fill [4];
    int rp [4];
    int wc [4];
    logic [7:0] dq [4];
    logic [8:0] exp_q [$];
    logic       p_stall = 1'b0;
    logic [7:0] p_data = 8'h00;

    adc_readout_arb dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .ch_mask   (ch_mask),
        .ch_end    (ch_end),
        .ch_empty  (ch_empty),
        .ch_data   (ch_data),
        .ch_rdreq  (ch_rdreq),
        .adc_bg    (adc_bg),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] byte_of(input int k, input int i);
        return 8'(16 * (k + 1) + i);
    endfunction

    // Normal-mode FIFO models, refilled on every capture restart.
    always @(posedge Clk) begin
        for (int k = 0; k < 4; k++) begin
            if (adc_bg) begin
                rp[k] <= 0;
                wc[k] <= fill[k];
            end else if (ch_rdreq[k]) begin
                dq[k] <= byte_of(k, rp[k]);
                rp[k] <= rp[k] + 1;
            end
        end
    end

    always_comb begin
        ch_empty = 4'h0;
        for (int k = 0; k < 4; k++) ch_empty[k] = (rp[k] >= wc[k]);
    end

    assign ch_data = {dq[3], dq[2], dq[1], dq[0]};

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge Clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on each accepted byte.
    always @(negedge Clk) begin
        logic [8:0] e;
        if (Reset_n && out_valid && p_stall) begin
            n_cmp++;
            if (out_data !== p_data) begin
                n_bad++;
                $display("FAIL stall_hold: got %h want %h", out_data, p_data);
            end
        end
        if (Reset_n && |ch_rdreq) begin
            n_cmp++;
            if ($countones(ch_rdreq) > 1) begin
                n_bad++;
                $display("FAIL rdreq_onehot: got %b want <=1 bit", ch_rdreq);
            end
        end
        if (Reset_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL extra_byte: got %b_%h want none",
                         out_last, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    n_bad++;
                    $display("FAIL stream_byte: got %b_%h want %b_%h",
                             out_last, out_data, e[8], e[7:0]);
                end
            end
            n_bytes++;
            if (out_last) n_frames++;
        end
        p_stall = Reset_n && out_valid && !out_ready;
        p_data  = out_data;
        if (ch_rdreq[1]) n_rd1++;
        if (adc_bg) n_bg++;
    end

    task automatic push_frame(input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                exp_q.push_back({1'b0, 8'hA0 + 8'(k)});
                for (int i = 0; i < fill[k]; i++)
                    exp_q.push_back({1'b0, byte_of(k, i)});
            end
        end
        exp_q.push_back({1'b1, 8'h55});
    endtask

    task automatic start_frame(input logic [3:0] m, input logic [3:0] endv);
        int g0;
        ch_end = 4'h0;
        push_frame(m);
        g0 = n_bg;
        @(negedge Clk);
        start = 1'b1;
        ch_mask = m;
        @(negedge Clk);
        start = 1'b0;
        ch_mask = 4'h0;
        for (int c = 0; c < 20; c++) begin
            if (n_bg != g0) break;
            @(negedge Clk);
        end
        repeat (3) @(negedge Clk);
        ch_end = endv;
    endtask

    task automatic wait_frame(input int f0, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (n_frames != f0) break;
            @(negedge Clk);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_last !== 1'b0) begin
            n_bad++; $display("FAIL rst_last: got %b want 0", out_last);
        end
        n_cmp++;
        if (out_data !== 8'h00) begin
            n_bad++; $display("FAIL rst_data: got %h want 00", out_data);
        end
        n_cmp++;
        if (ch_rdreq !== 4'h0) begin
            n_bad++; $display("FAIL rst_rdreq: got %b want 0000", ch_rdreq);
        end
        n_cmp++;
        if (adc_bg !== 1'b0) begin
            n_bad++; $display("FAIL rst_bg: got %b want 0", adc_bg);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_basic(input int mode, input string nm);
        int f0, b0, g0;
        ready_mode = mode;
        fill = '{3, 3, 3, 3};
        f0 = n_frames; b0 = n_bytes; g0 = n_bg;
        start_frame(4'b0101, 4'hF);
        wait_frame(f0, 400);
        n_cmp++;
        if (n_frames - f0 !== 1) begin
            n_bad++; $display("FAIL %s_frame: got %0d want 1", nm, n_frames - f0);
        end
        n_cmp++;
        if (n_bytes - b0 !== 9) begin
            n_bad++; $display("FAIL %s_bytes: got %0d want 9", nm, n_bytes - b0);
        end
        n_cmp++;
        if (n_bg - g0 !== 1) begin
            n_bad++; $display("FAIL %s_bg: got %0d want 1", nm, n_bg - g0);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL %s_left: got %0d want 0", nm, exp_q.size());
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_idle: got %b want 0", nm, busy);
        end
        ready_mode = 0;
        exp_q.delete();
    endtask

    task automatic test_empty_chan();
        int f0, r0;
        fill = '{3, 0, 2, 1};
        f0 = n_frames; r0 = n_rd1;
        start_frame(4'b0111, 4'hF);
        wait_frame(f0, 400);
        n_cmp++;
        if (n_frames - f0 !== 1) begin
            n_bad++; $display("FAIL empty_frame: got %0d want 1", n_frames - f0);
        end
        n_cmp++;
        if (n_rd1 - r0 !== 0) begin
            n_bad++; $display("FAIL empty_rd1: got %0d want 0", n_rd1 - r0);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL empty_left: got %0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_start_ignored();
        int f0, b0, g0;
        fill = '{2, 2, 0, 0};
        f0 = n_frames; b0 = n_bytes; g0 = n_bg;
        start_frame(4'b0011, 4'hF);
        for (int c = 0; c < 100; c++) begin
            if (n_bytes - b0 >= 2) break;
            @(negedge Clk);
        end
        for (int c = 0; c < 10; c++) begin
            if (out_valid) break;
            @(negedge Clk);
        end
        start = 1'b1;
        ch_mask = 4'hF;
        @(negedge Clk);
        start = 1'b0;
        ch_mask = 4'h0;
        wait_frame(f0, 400);
        repeat (10) @(negedge Clk);
        n_cmp++;
        if (n_bytes - b0 !== 7) begin
            n_bad++; $display("FAIL ign_bytes: got %0d want 7", n_bytes - b0);
        end
        n_cmp++;
        if (n_bg - g0 !== 1) begin
            n_bad++; $display("FAIL ign_bg: got %0d want 1", n_bg - g0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL ign_idle: got %b want 0", busy);
        end
        g0 = n_bg;
        start = 1'b1;
        ch_mask = 4'h0;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL mask0_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (n_bg !== g0) begin
            n_bad++; $display("FAIL mask0_bg: got %0d want %0d", n_bg, g0);
        end
        exp_q.delete();
    endtask

    task automatic test_end_wait();
        int f0, viol;
        fill = '{1, 1, 1, 1};
        f0 = n_frames;
        viol = 0;
        start_frame(4'hF, 4'b0111);
        for (int c = 0; c < 1000; c++) begin
            @(negedge Clk);
            if (out_valid) viol++;
        end
        n_cmp++;
        if (viol !== 0) begin
            n_bad++; $display("FAIL endwait_early: got %0d want 0", viol);
        end
        ch_end = 4'hF;
        wait_frame(f0, 400);
        n_cmp++;
        if (n_frames - f0 !== 1) begin
            n_bad++; $display("FAIL endwait_frame: got %0d want 1", n_frames - f0);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL endwait_left: got %0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int f0, b0;
        logic seen;
        fill = '{3, 0, 0, 0};
        ready_mode = 0;
        b0 = n_bytes;
        seen = 1'b0;
        start_frame(4'b0001, 4'hF);
        for (int c = 0; c < 100; c++) begin
            if (n_bytes != b0) break;
            @(negedge Clk);
        end
        ready_mode = 2;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++; $display("FAIL mid_send: got %b want 1", seen);
        end
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, out_valid, out_last, adc_bg} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_ctrl: got %b want 0000",
                     {busy, out_valid, out_last, adc_bg});
        end
        n_cmp++;
        if (out_data !== 8'h00) begin
            n_bad++; $display("FAIL mid_data: got %h want 00", out_data);
        end
        n_cmp++;
        if (ch_rdreq !== 4'h0) begin
            n_bad++; $display("FAIL mid_rdreq: got %b want 0000", ch_rdreq);
        end
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        ready_mode = 0;
        @(negedge Clk);
        f0 = n_frames;
        start_frame(4'b0001, 4'hF);
        wait_frame(f0, 400);
        n_cmp++;
        if (n_frames - f0 !== 1) begin
            n_bad++; $display("FAIL mid_frame: got %0d want 1", n_frames - f0);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL mid_left: got %0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        fill = '{0, 0, 0, 0};
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "stall");
        test_empty_chan();
        test_start_ignored();
        test_end_wait();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
